// File: rtl/dwt_pkg.sv
// Shared constants and helpers for the Haar DWT engine (control logic and MAC unit).
package dwt_pkg;

    localparam int WIDTH  = 256;
    localparam int HEIGHT = 256;
    localparam int PW     = $clog2(WIDTH);

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    localparam int DETAIL_OFFSET = 128;

    // True when {mode, rc, px} names the final pair of a row or column pass.
    function automatic logic is_last_pair(input logic        mode,
                                          input int unsigned rc,
                                          input int unsigned px,
                                          input int unsigned width,
                                          input int unsigned height);
        if (mode == MODE_ROW)
            return (px == width - 2) && (rc == height - 1);
        else
            return (px == height - 2) && (rc == width - 1);
    endfunction

endpackage

// File: rtl/haar_seq_checker.sv
// Tracks the expected {mode, rc, px} tag and raises a sticky flag on out-of-order pairs.
// The expected tag always resyncs from the received tag, so one bad pair gives one flag event.
module haar_seq_checker
    import dwt_pkg::*;
#(
    parameter int WIDTH  = dwt_pkg::WIDTH,
    parameter int HEIGHT = dwt_pkg::HEIGHT,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          mode,
    input  logic [PW-1:0] rc,
    input  logic [PW-1:0] px,
    input  logic          err_clear,
    output logic          seq_err
);

    logic          exp_mode;
    logic [PW-1:0] exp_rc;
    logic [PW-1:0] exp_px;
    logic          mismatch;
    logic          nxt_mode;
    logic [PW-1:0] nxt_rc;
    logic [PW-1:0] nxt_px;
    int unsigned   line_end;

    // Compare against the expected tag and derive the successor of the received tag.
    always_comb begin
        mismatch = valid && ((mode != exp_mode) || (rc != exp_rc) || (px != exp_px));
        line_end = (mode == MODE_ROW) ? 32'(WIDTH - 2) : 32'(HEIGHT - 2);
        nxt_mode = mode;
        nxt_rc   = rc;
        nxt_px   = px + PW'(2);
        if (is_last_pair(mode, 32'(rc), 32'(px), WIDTH, HEIGHT)) begin
            nxt_mode = ~mode;
            nxt_rc   = '0;
            nxt_px   = '0;
        end else if (32'(px) == line_end) begin
            nxt_rc = rc + PW'(1);
            nxt_px = '0;
        end
    end

    // Expected-tag register and sticky error; a new mismatch overrides a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_mode <= MODE_ROW;
            exp_rc   <= '0;
            exp_px   <= '0;
            seq_err  <= 1'b0;
        end else begin
            if (valid) begin
                exp_mode <= nxt_mode;
                exp_rc   <= nxt_rc;
                exp_px   <= nxt_px;
            end
            if (mismatch)
                seq_err <= 1'b1;
            else if (err_clear)
                seq_err <= 1'b0;
        end
    end

endmodule

// File: rtl/haar_mac_unit.sv
// Three-stage Haar approximation/detail responder with tag echo and pass-boundary pulse.
module haar_mac_unit
    import dwt_pkg::*;
#(
    parameter int WIDTH  = dwt_pkg::WIDTH,
    parameter int HEIGHT = dwt_pkg::HEIGHT,
    localparam int PW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   i_mac,
    input  logic          i_mac_valid,
    input  logic          i_mac_mode,
    input  logic [PW-1:0] i_mac_row_column_pointer,
    input  logic [PW-1:0] i_mac_pixel_pointer,
    input  logic          i_err_clear,
    output logic [15:0]   o_mac,
    output logic          o_mac_valid,
    output logic          o_mac_mode,
    output logic [PW-1:0] o_mac_row_column_pointer,
    output logic [PW-1:0] o_mac_pixel_pointer,
    output logic          o_pass_done,
    output logic          o_seq_err
);

    logic              s1_valid, s1_mode;
    logic [PW-1:0]     s1_rc, s1_px;
    logic [7:0]        s1_p0, s1_p1;

    logic              s2_valid, s2_mode;
    logic [PW-1:0]     s2_rc, s2_px;
    logic [8:0]        s2_sum;
    logic signed [8:0] s2_diff;

    logic signed [9:0] d_rnd, d_shift, d_off;
    logic [7:0]        approx, detail;
    logic              s2_last;

    // Stage 1: capture the pair and its tag; data holds across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_rc    <= '0;
            s1_px    <= '0;
            s1_p0    <= '0;
            s1_p1    <= '0;
        end else begin
            s1_valid <= i_mac_valid;
            if (i_mac_valid) begin
                s1_mode <= i_mac_mode;
                s1_rc   <= i_mac_row_column_pointer;
                s1_px   <= i_mac_pixel_pointer;
                s1_p0   <= i_mac[15:8];
                s1_p1   <= i_mac[7:0];
            end
        end
    end

    // Stage 2: unsigned sum and two's-complement difference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_rc    <= '0;
            s2_px    <= '0;
            s2_sum   <= '0;
            s2_diff  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mode <= s1_mode;
                s2_rc   <= s1_rc;
                s2_px   <= s1_px;
                s2_sum  <= {1'b0, s1_p0} + {1'b0, s1_p1};
                s2_diff <= {1'b0, s1_p0} - {1'b0, s1_p1};
            end
        end
    end

    // Rounded halves; detail is offset-binary and only +256 (diff=255) needs clamping.
    always_comb begin
        approx  = 8'((10'(s2_sum) + 10'd1) >> 1);
        d_rnd   = {s2_diff[8], s2_diff} + 10'sd1;
        d_shift = d_rnd >>> 1;
        d_off   = d_shift + 10'(DETAIL_OFFSET);
        detail  = (d_off > 10'sd255) ? 8'hFF : d_off[7:0];
        s2_last = is_last_pair(s2_mode, 32'(s2_rc), 32'(s2_px), WIDTH, HEIGHT);
    end

    // Stage 3: registered outputs; data and tags hold when no result is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_mac_valid              <= 1'b0;
            o_pass_done              <= 1'b0;
            o_mac                    <= '0;
            o_mac_mode               <= 1'b0;
            o_mac_row_column_pointer <= '0;
            o_mac_pixel_pointer      <= '0;
        end else begin
            o_mac_valid <= s2_valid;
            o_pass_done <= s2_valid && s2_last;
            if (s2_valid) begin
                o_mac                    <= {approx, detail};
                o_mac_mode               <= s2_mode;
                o_mac_row_column_pointer <= s2_rc;
                o_mac_pixel_pointer      <= s2_px;
            end
        end
    end

    haar_seq_checker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_seq_checker (
        .clk       (clk),
        .rst       (rst),
        .valid     (i_mac_valid),
        .mode      (i_mac_mode),
        .rc        (i_mac_row_column_pointer),
        .px        (i_mac_pixel_pointer),
        .err_clear (i_err_clear),
        .seq_err   (o_seq_err)
    );

endmodule

// File: tb/tb_haar_mac_unit.sv
// Self-checking bench for haar_mac_unit at WIDTH=HEIGHT=8.
module tb_haar_mac_unit;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   i_mac = '0;
    logic          i_mac_valid = 1'b0;
    logic          i_mac_mode = 1'b0;
    logic [PW-1:0] i_mac_row_column_pointer = '0;
    logic [PW-1:0] i_mac_pixel_pointer = '0;
    logic          i_err_clear = 1'b0;
    logic [15:0]   o_mac;
    logic          o_mac_valid;
    logic          o_mac_mode;
    logic [PW-1:0] o_mac_row_column_pointer;
    logic [PW-1:0] o_mac_pixel_pointer;
    logic          o_pass_done;
    logic          o_seq_err;

    haar_mac_unit #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_mac                    (i_mac),
        .i_mac_valid              (i_mac_valid),
        .i_mac_mode               (i_mac_mode),
        .i_mac_row_column_pointer (i_mac_row_column_pointer),
        .i_mac_pixel_pointer      (i_mac_pixel_pointer),
        .i_err_clear              (i_err_clear),
        .o_mac                    (o_mac),
        .o_mac_valid              (o_mac_valid),
        .o_mac_mode               (o_mac_mode),
        .o_mac_row_column_pointer (o_mac_row_column_pointer),
        .o_mac_pixel_pointer      (o_mac_pixel_pointer),
        .o_pass_done              (o_pass_done),
        .o_seq_err                (o_seq_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit v;
        int m, r, x, a, b;
    } pair_t;

    typedef struct {
        int a, b, exp;
    } vec_t;

    // Reference model state: 3-deep delay line, last delivered result, expected tag, error flag.
    pair_t pipe [3];
    int    held_data, held_m, held_r, held_x;
    int    m_mode, m_rc, m_px;
    bit    m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int haar(input int a, input int b);
        int ap, d, t, det;
        ap = (a + b + 1) / 2;
        d  = a - b + 1;
        if (d >= 0) t = d / 2;
        else        t = -((-d + 1) / 2);
        det = t + 128;
        if (det > 255) det = 255;
        return ap * 256 + det;
    endfunction

    function automatic bit is_last(input int m, input int r, input int x);
        if (m == 0) return (x == W - 2) && (r == H - 1);
        else        return (x == H - 2) && (r == W - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
        held_data = 0; held_m = 0; held_r = 0; held_x = 0;
        m_mode = 0; m_rc = 0; m_px = 0; m_err = 0;
    endtask

    // Present one cycle of input, advance the model, clock, and compare every output.
    task automatic step(input bit v, input int a, input int b, input int m,
                        input int r, input int x, input bit c);
        int lend;
        i_mac_valid = v;
        i_mac = {a[7:0], b[7:0]};
        i_mac_mode = m[0];
        i_mac_row_column_pointer = r[PW-1:0];
        i_mac_pixel_pointer = x[PW-1:0];
        i_err_clear = c;
        if (v && (m != m_mode || r != m_rc || x != m_px)) m_err = 1;
        else if (c) m_err = 0;
        if (v) begin
            lend = (m == 0) ? W - 2 : H - 2;
            if (is_last(m, r, x)) begin
                m_mode = 1 - m; m_rc = 0; m_px = 0;
            end else if (x == lend) begin
                m_mode = m; m_rc = (r + 1) % (1 << PW); m_px = 0;
            end else begin
                m_mode = m; m_rc = r; m_px = (x + 2) % (1 << PW);
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{v, m, r, x, a, b};
        if (pipe[2].v) begin
            held_data = haar(pipe[2].a, pipe[2].b);
            held_m = pipe[2].m; held_r = pipe[2].r; held_x = pipe[2].x;
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(o_mac_valid), 32'(pipe[2].v));
        chk("data", 32'(o_mac), held_data);
        chk("tag", {o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer},
            {held_m[0], held_r[PW-1:0], held_x[PW-1:0]});
        chk("pass_done", 32'(o_pass_done),
            32'(pipe[2].v && is_last(pipe[2].m, pipe[2].r, pipe[2].x)));
        chk("seq_err", 32'(o_seq_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges, confirm outputs clear without a clock, then release.
    task automatic do_reset();
        i_mac_valid = 0; i_err_clear = 0;
        rst = 0;
        #1;
        chk("async_reset_outputs",
            {o_mac, o_mac_valid, o_mac_mode, o_mac_row_column_pointer,
             o_mac_pixel_pointer, o_pass_done, o_seq_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1;
        model_reset();
    endtask

    vec_t vecs [9];
    bit   obs [8];
    bit   pat [5];
    int   nvalid, ndone, dtag;

    initial begin
        vecs[0] = '{200, 100, 16'h96B2};
        vecs[1] = '{0,   255, 16'h8001};
        vecs[2] = '{255, 0,   16'h80FF};
        vecs[3] = '{0,   0,   16'h0080};
        vecs[4] = '{255, 255, 16'hFF80};
        vecs[5] = '{1,   0,   16'h0181};
        vecs[6] = '{0,   1,   16'h0180};
        vecs[7] = '{0,   2,   16'h017F};
        vecs[8] = '{254, 0,   16'h7FFF};
        pat = '{1, 0, 1, 1, 0};

        model_reset();
        @(posedge clk); #1;
        chk("reset_state", {o_mac, o_mac_valid, o_pass_done, o_seq_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1;

        // Single pair latency: result appears on the third edge counting the sampling edge.
        step(1, 200, 100, 0, 3, 4, 0);
        chk("lat_edge1_valid", 32'(o_mac_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_edge2_valid", 32'(o_mac_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_edge3_valid", 32'(o_mac_valid), 32'd1);
        chk("lat_edge3_data", 32'(o_mac), 32'h96B2);
        chk("lat_edge3_tag", {o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer},
            {1'b0, 3'd3, 3'd4});
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lat_hold_data", 32'(o_mac), 32'h96B2);

        // Table of arithmetic vectors, each sent alone with the tag the checker expects.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            step(1, vecs[i].a, vecs[i].b, 0, 0, 0, 0);
            idle(2);
            chk($sformatf("vec%0d_data", i), 32'(o_mac), 32'(vecs[i].exp));
        end

        // Full legal row pass followed by a column pass.
        do_reset();
        nvalid = 0; ndone = 0; dtag = -1;
        for (int r = 0; r < H; r++)
            for (int x = 0; x < W; x += 2) begin
                step(1, $urandom_range(255), $urandom_range(255), 0, r, x, 0);
                if (o_mac_valid) nvalid++;
                if (o_pass_done) begin
                    ndone++;
                    dtag = {o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer};
                end
            end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (o_mac_valid) nvalid++;
            if (o_pass_done) begin
                ndone++;
                dtag = {o_mac_mode, o_mac_row_column_pointer, o_mac_pixel_pointer};
            end
        end
        chk("row_pass_valid_count", nvalid, 32);
        chk("row_pass_done_count", ndone, 1);
        chk("row_pass_done_tag", dtag, {1'b0, 3'd7, 3'd6});
        chk("row_pass_err", 32'(o_seq_err), 32'd0);
        for (int c = 0; c < W; c++)
            for (int x = 0; x < H; x += 2)
                step(1, $urandom_range(255), $urandom_range(255), 1, c, x, 0);
        idle(3);
        chk("col_pass_err", 32'(o_seq_err), 32'd0);

        // Out-of-order pair, resync, clear, and clear colliding with a mismatch.
        do_reset();
        step(1, 10, 20, 0, 0, 0, 0);
        chk("ooo_first_ok", 32'(o_seq_err), 32'd0);
        step(1, 10, 20, 0, 0, 4, 0);
        chk("ooo_flag_set", 32'(o_seq_err), 32'd1);
        step(1, 10, 20, 0, 0, 6, 0);
        chk("ooo_sticky", 32'(o_seq_err), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("ooo_clear", 32'(o_seq_err), 32'd0);
        step(1, 30, 40, 0, 1, 0, 0);
        chk("ooo_resync_ok", 32'(o_seq_err), 32'd0);
        step(1, 30, 40, 0, 0, 2, 1);
        chk("ooo_set_wins", 32'(o_seq_err), 32'd1);
        idle(3);

        // Reset with three pairs in flight.
        do_reset();
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 3, 4, 0, 0, 2, 0);
        step(1, 5, 6, 0, 0, 4, 0);
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (o_mac_valid) nvalid++;
        end
        chk("flush_no_valid", nvalid, 0);
        step(1, 9, 9, 0, 0, 0, 0);
        chk("flush_first_ok", 32'(o_seq_err), 32'd0);
        idle(3);

        // Bubble pattern 1,0,1,1,0 reproduced two steps later on o_mac_valid.
        do_reset();
        begin
            int xp;
            xp = 0;
            for (int k = 0; k < 8; k++) begin
                if (k < 5 && pat[k]) begin
                    step(1, 17 * (k + 1), 200 - 13 * k, 0, 0, xp, 0);
                    xp += 2;
                end else begin
                    step(0, 0, 0, 0, 0, 0, 0);
                end
                obs[k] = o_mac_valid;
            end
        end
        chk("bubble_lead0", 32'(obs[0]), 32'd0);
        chk("bubble_lead1", 32'(obs[1]), 32'd0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("bubble_slot%0d", k), 32'(obs[k + 2]), 32'(pat[k]));

        // Random traffic, mostly legal order, occasional disorder and clears.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit v, c;
            int m, r, x;
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(15) == 0);
            if ($urandom_range(9) == 0) begin
                m = $urandom_range(1); r = $urandom_range(7); x = $urandom_range(7);
            end else begin
                m = m_mode; r = m_rc; x = m_px;
            end
            step(v, $urandom_range(255), $urandom_range(255), m, r, x, c);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
